// File: rtl/pipe_pkg.sv
// Shared types and default widths for handshaked pipeline stage registers.
package pipe_pkg;

  localparam int DATA_W_DEF = 128;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } pipe_occ_t;

  // Decoded-instruction bundle carried across the ID->EX boundary; packs to exactly 128 bits.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [19:0] imm;
    logic [4:0]  rd;
    logic [3:0]  aluOp;
    logic        isLoad;
    logic        isStore;
    logic        regWrite;
  } id_ex_bundle_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush, bubble insertion and a stall counter.
// Define PIPE_SKID_EN to add a skid entry so in_ready comes from a register.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              bubble,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_occ_t         state_q;
  logic [DATA_W-1:0] mainData_q;
  logic              mainValid;
  logic              accept;
  logic              fire;

  assign mainValid = (state_q != OCC_EMPTY);
  assign out_valid = mainValid && !flush;
  assign out_data  = mainData_q;
  assign occupancy = state_q;

`ifdef PIPE_SKID_EN
  logic [DATA_W-1:0] skidData_q;

  // Only the registered FULL state gates in_ready, so no path runs from out_ready.
  assign in_ready = (state_q != OCC_FULL) && !bubble && !flush;
`else
  assign in_ready = (!mainValid || out_ready) && !bubble && !flush;
`endif

  assign accept = in_valid && in_ready;
  assign fire   = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= OCC_EMPTY;
      mainData_q <= '0;
`ifdef PIPE_SKID_EN
      skidData_q <= '0;
`endif
    end else if (flush) begin
      state_q    <= OCC_EMPTY;
      mainData_q <= '0;
`ifdef PIPE_SKID_EN
      skidData_q <= '0;
`endif
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (accept) begin
            state_q    <= OCC_ONE;
            mainData_q <= in_data;
          end
        end
        OCC_ONE: begin
          if (accept && fire) begin
            mainData_q <= in_data;
`ifdef PIPE_SKID_EN
          end else if (accept) begin
            state_q    <= OCC_FULL;
            skidData_q <= in_data;
`endif
          end else if (fire) begin
            state_q    <= OCC_EMPTY;
            mainData_q <= '0;
          end
        end
`ifdef PIPE_SKID_EN
        OCC_FULL: begin
          if (fire) begin
            state_q    <= OCC_ONE;
            mainData_q <= skidData_q;
            skidData_q <= '0;
          end
        end
`endif
        default: begin
          state_q    <= OCC_EMPTY;
          mainData_q <= '0;
        end
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stallCnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr_cnt),
    .en_i    (out_valid && !out_ready),
    .count_o (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg against a queue-based reference model.
// Follows PIPE_SKID_EN to choose the model capacity (2 with skid, 1 without).
module tb_pipe_stage_reg;

  localparam int DW     = 32;
  localparam int CW     = 4;
  localparam int CNTMAX = (1 << CW) - 1;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          bubble;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic          clr_cnt;
  logic [CW-1:0] stall_cnt;

  int            checkCount;
  int            errCount;
  logic [DW-1:0] modelQ[$];
  int            modelCnt;

  pipe_stage_reg #(
    .DATA_W(DW),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bubble    (bubble),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .clr_cnt   (clr_cnt),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Drives one cycle from a negedge, checks outputs against the model, then advances the model.
  task automatic applyStimulus(input logic iv, input logic [DW-1:0] id, input logic ordy,
                               input logic fl, input logic bb, input logic clr);
    logic        expOutValid;
    logic        expInReady;
    logic [63:0] expData;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    bubble    = bb;
    clr_cnt   = clr;
    #1;
    expOutValid = (modelQ.size() > 0) && !fl;
    if (SKID) expInReady = (modelQ.size() < 2) && !bb && !fl;
    else      expInReady = ((modelQ.size() == 0) || ordy) && !bb && !fl;
    expData = (modelQ.size() > 0) ? 64'(modelQ[0]) : 64'd0;
    checkOutput("out_valid", 64'(out_valid), 64'(expOutValid));
    checkOutput("in_ready", 64'(in_ready), 64'(expInReady));
    checkOutput("occupancy", 64'(occupancy), 64'(modelQ.size()));
    if (!fl) checkOutput("out_data", 64'(out_data), expData);
    checkOutput("stall_cnt", 64'(stall_cnt), 64'(modelCnt));
    @(posedge clk);
    if (fl) begin
      modelQ.delete();
    end else begin
      if (expOutValid && ordy) void'(modelQ.pop_front());
      if (iv && expInReady) modelQ.push_back(id);
    end
    if (clr) modelCnt = 0;
    else if (expOutValid && !ordy && modelCnt < CNTMAX) modelCnt++;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount = 0;
    errCount   = 0;
    modelCnt   = 0;
    rst_n      = 1'b0;
    flush      = 1'b0;
    bubble     = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    clr_cnt    = 1'b0;
    #3;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
    checkOutput("rst_out_data", 64'(out_data), 64'd0);
    checkOutput("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] streaming 0x1..0x8");
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, DW'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("stream_stall_cnt", 64'(stall_cnt), 64'd0);

    $display("[TB] backpressure absorb");
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, DW'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, DW'(32'h10 + k), 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("absorb_stall_cnt", 64'(stall_cnt), 64'd3);
    if (SKID) checkOutput("absorb_occupancy", 64'(occupancy), 64'd2);
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, DW'(32'h20 + k), 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] flush with held entries");
    applyStimulus(1'b1, DW'(32'hA), 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, DW'(32'hB), 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, DW'(32'hC), 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] bubble for two cycles");
    applyStimulus(1'b1, DW'(32'h5), 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, DW'(32'h6), 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, DW'(32'h6), 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, DW'(32'h6), 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] counter saturation");
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, DW'(32'h9), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("sat_stall_cnt", 64'(stall_cnt), 64'(CNTMAX));
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_stall_cnt", 64'(stall_cnt), 64'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] asynchronous reset while holding data");
    applyStimulus(1'b1, DW'(32'h31), 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, DW'(32'h32), 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_rst_occupancy", 64'(occupancy), SKID ? 64'd2 : 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("arst_occupancy", 64'(occupancy), 64'd0);
    checkOutput("arst_out_data", 64'(out_data), 64'd0);
    checkOutput("arst_stall_cnt", 64'(stall_cnt), 64'd0);
    checkOutput("arst_in_ready", 64'(in_ready), 64'd1);
    modelQ.delete();
    modelCnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, DW'(32'h77), 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 3) != 0), DW'($urandom),
                    ($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
